spi_bitrev_slave: RTL and testbench
===================================

// Module: spi_bitrev_slave
// PURPOSE
//  Parametrised SPI slave loopback device on the SoC peripheral bus: receives a DATA_W-bit word,
//  then returns it bit-reversed in the following DATA_W SCK cycles of the same SS-low window.
//  Generalises the fixed 8-bit, mode-0, SCK-clocked device: runs on the system clock with
//  oversampled SCK, supports all four SPI modes, has a true reset, and adds status/telemetry outputs.
// PARAMETERS
//  DATA_W       8   frame width in bits, legal 2..32
//  CPOL         0   SCK idle level
//  CPHA         0   0: sample on leading edge; 1: sample on trailing edge
//  SYNC_STAGES  2   synchroniser depth on sck/ss/mosi, legal >= 2
//  CNT_W        16  width of frame_cnt
// PORTS
//  clock        in   1        system clock; must be >= 8x SCK frequency
//  resetn       in   1        asynchronous, active-low reset
//  sck          in   1        SPI clock (async to clock)
//  ss           in   1        SPI select, active low (async)
//  mosi         in   1        SPI data in (async)
//  miso         out  1        SPI data out
//  rx_data      out  DATA_W   last fully received word, first-received bit in MSB
//  rx_valid     out  1        1-cycle pulse when the RX phase completes
//  frame_done   out  1        1-cycle pulse when the TX phase completes
//  frame_abort  out  1        1-cycle pulse when ss rises during RX or TX
//  frame_cnt    out  CNT_W    completed-frame count, wraps to 0 after all-ones
// BEHAVIOUR
//  Reset: state IDLE, miso=1, rx_data=0, rx_valid/frame_done/frame_abort=0, frame_cnt=0.
//   Synchroniser flops reset to sck=CPOL, ss=1, mosi=0, so no false edge after reset.
//  Edges: sample edge = rising of synced sck when CPOL==CPHA, else falling; shift edge = opposite.
//   Edge detection occurs after the synchroniser, so miso/status change SYNC_STAGES+1 clocks after the pin edge.
//  Edges are acted on only while synced ss==0. ss==1 forces state IDLE and miso=1.
//  FSM: IDLE -> RX -> TX -> IDLE.
//   IDLE: miso=1; the first sample edge loads mosi into rx_shift[DATA_W-1], bit_cnt=1, goes to RX.
//   RX: each sample edge shifts mosi in MSB-first and increments bit_cnt.
//    The DATA_W-th sample copies the word to rx_data, pulses rx_valid, clears bit_cnt, and goes to TX.
//    miso=0 while in RX.
//   TX: each shift edge drives miso = rx_shift[bit_cnt] and increments bit_cnt, so LSB goes first
//    and the word is reversed. Shift edges in IDLE or RX do not change miso.
//    After the DATA_W-th TX sample edge: pulse frame_done, increment frame_cnt, go to IDLE.
//    miso holds its last bit until ss rises or the next frame starts.
//  Back-to-back: further SCK cycles with ss still low start a new frame from IDLE.
//  Abort: synced ss rising in RX or TX pulses frame_abort and returns to IDLE.
//   The abort leaves rx_data and frame_cnt unchanged and discards the partial word.
//   A synced ss rising in IDLE produces no pulse.
//  A synced ss falling edge clears bit_cnt, so a glitch frame never carries over.
//  Simultaneous: ss rise and sample edge in the same cycle -> abort wins and the edge is ignored.
//  Async reset mid-frame returns everything to reset values immediately.
//   The first frame after reset starts cleanly on the next ss-low window.
//  bit_cnt width is $clog2(DATA_W)+1. frame_cnt wraps modulo 2^CNT_W.
// STRUCTURE
//  Package spi_pkg: enum spi_state_e {IDLE, RX, TX}; function sample_on_rise(CPOL, CPHA).
//  Sub-module spi_sync_edge: SYNC_STAGES flop synchroniser with rise/fall pulse outputs and reset value.
//   Three instances: sck, ss, mosi (mosi uses only the level output).
//  Top: FSM, rx_shift, bit_cnt, frame_cnt, and a registered miso driver.
// TESTING
//  1. Mode 0, DATA_W=8, send 0xB1 -> rx_data=0xB1, rx_valid once; TX bits read as 0x8D MSB-first;
//     frame_done once, frame_cnt=1.
//  2. Modes 1, 2 and 3 each with 0x01 -> master reads 0x80; no extra or missing bits.
//  3. DATA_W=16, send 0x1234 in one SS window -> 0x2C48 returned, frame_cnt=1.
//  4. Two frames 0xF0, 0x0F in one SS window -> returns 0x0F, 0xF0; frame_cnt=2.
//  5. ss rises after 5 RX bits -> frame_abort pulse, miso=1, rx_data and frame_cnt unchanged.
//     Next full frame with 0xA5 is correct (0xA5 returned).
//  6. resetn low mid-TX -> miso=1, counters 0 immediately; then frame_cnt preset to all-ones
//     plus one more frame -> frame_cnt wraps to 0.

Source files
------------

// File: rtl/spi_bitrev_slave_pkg.sv
// Shared types and helpers for the bit-reversing SPI loopback slave.
//   spi_state_e    : frame sequencer states (idle, receive, transmit)
//   sample_on_rise : for a given CPOL/CPHA, 1 when the slave samples MOSI on
//                    the rising edge of SCK and 0 when it samples on falling
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RX   = 2'd1,
    TX   = 2'd2
  } spi_state_e;

  // Leading edge samples when CPHA=0; the leading edge is rising when CPOL=0.
  // The two cancel out, so sampling is on rising SCK whenever CPOL equals CPHA.
  function automatic logic sample_on_rise(input logic cpol, input logic cpha);
    return (cpol == cpha);
  endfunction

endpackage

// File: rtl/spi_bitrev_slave_if.sv
// SPI pin bundle for the bit-reversing loopback slave.
//   sck  : SPI clock, driven by the master
//   ss   : slave select, active low, driven by the master
//   mosi : master-to-slave data
//   miso : slave-to-master data
// The slave modport faces the device, the master modport faces the bus master.
interface spi_bitrev_slave_if;

  logic sck;
  logic ss;
  logic mosi;
  logic miso;

  modport slave  (input  sck, ss, mosi, output miso);
  modport master (output sck, ss, mosi, input  miso);

endinterface

// File: rtl/spi_bitrev_slave_sync.sv
// Multi-flop synchroniser with edge detection for one asynchronous pin.
//   clock   : system clock
//   resetn  : asynchronous active-low reset
//   din     : asynchronous pin
//   level   : synchronised level, STAGES clocks behind the pin
//   rise    : 1-cycle pulse when level goes 0 -> 1
//   fall    : 1-cycle pulse when level goes 1 -> 0
// Every flop, including the edge-detect history, resets to RST_VAL so that
// leaving reset with the pin already at its idle level produces no edge.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clock,
  input  logic resetn,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_bitrev_slave.sv
// SPI slave loopback: receives a DATA_W-bit word MSB-first, then returns it
// bit-reversed (LSB of the received word first) during the next DATA_W SCK
// cycles of the same select window. Runs on the oversampling system clock and
// supports all four SPI modes via CPOL/CPHA.
//   clock       : system clock, at least 8x the SCK frequency
//   resetn      : asynchronous active-low reset
//   spi         : SPI pins (sck, ss, mosi in; miso out)
//   rx_data     : last fully received word, first-received bit in MSB
//   rx_valid    : 1-cycle pulse when the receive phase completes
//   frame_done  : 1-cycle pulse when the transmit phase completes
//   frame_abort : 1-cycle pulse when select rises mid-frame
//   frame_cnt   : completed-frame count, wraps modulo 2^CNT_W
module spi_bitrev_slave
  import spi_pkg::*;
#(
  parameter int   DATA_W      = 8,
  parameter logic CPOL        = 1'b0,
  parameter logic CPHA        = 1'b0,
  parameter int   SYNC_STAGES = 2,
  parameter int   CNT_W       = 16
) (
  input  logic                   clock,
  input  logic                   resetn,
  spi_bitrev_slave_if.slave      spi,
  output logic [DATA_W-1:0]      rx_data,
  output logic                   rx_valid,
  output logic                   frame_done,
  output logic                   frame_abort,
  output logic [CNT_W-1:0]       frame_cnt
);

  localparam int   IW          = $clog2(DATA_W);
  localparam int   BW          = IW + 1;
  localparam logic SAMPLE_RISE = sample_on_rise(CPOL, CPHA);

  logic sck_rise, sck_fall, unused_sck_lvl;
  logic ss_lvl, ss_rise, ss_fall;
  logic mosi_lvl, unused_mosi_rise, unused_mosi_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sck_sync (
    .clock (clock),
    .resetn(resetn),
    .din   (spi.sck),
    .level (unused_sck_lvl),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
    .clock (clock),
    .resetn(resetn),
    .din   (spi.ss),
    .level (ss_lvl),
    .rise  (ss_rise),
    .fall  (ss_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi_sync (
    .clock (clock),
    .resetn(resetn),
    .din   (spi.mosi),
    .level (mosi_lvl),
    .rise  (unused_mosi_rise),
    .fall  (unused_mosi_fall)
  );

  logic sample_edge, shift_edge;
  assign sample_edge = SAMPLE_RISE ? sck_rise : sck_fall;
  assign shift_edge  = SAMPLE_RISE ? sck_fall : sck_rise;

  spi_state_e        state_q, state_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              miso_q, miso_d;
  logic              rx_valid_q, rx_valid_d;
  logic              done_q, done_d;
  logic              abort_q, abort_d;

  // During RX the bit counter points at the next bit to write counting down
  // from the MSB; during TX it points at the next bit to send counting up
  // from the LSB, which is what reverses the word on the wire.
  logic [IW-1:0] wr_idx, rd_idx;
  assign wr_idx = IW'(DATA_W - 1) - bit_cnt_q[IW-1:0];
  assign rd_idx = bit_cnt_q[IW-1:0];

  // All state and datapath registers, including the registered miso driver.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      cnt_q      <= '0;
      miso_q     <= 1'b1;
      rx_valid_q <= 1'b0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      cnt_q      <= cnt_d;
      miso_q     <= miso_d;
      rx_valid_q <= rx_valid_d;
      done_q     <= done_d;
      abort_q    <= abort_d;
    end
  end

  // Next-state logic. A rising select is checked first so that it overrides
  // any SCK edge arriving in the same cycle; while select is high the slave
  // is parked in IDLE with miso released high. The TX completion test comes
  // before the shift test because the final sample edge arrives with the
  // counter already at DATA_W.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    cnt_d      = cnt_q;
    miso_d     = miso_q;
    rx_valid_d = 1'b0;
    done_d     = 1'b0;
    abort_d    = 1'b0;

    if (ss_rise) begin
      abort_d = (state_q != IDLE);
      state_d = IDLE;
      miso_d  = 1'b1;
    end else if (ss_lvl) begin
      state_d = IDLE;
      miso_d  = 1'b1;
    end else begin
      if (ss_fall) begin
        bit_cnt_d = '0;
      end
      unique case (state_q)
        IDLE: begin
          if (sample_edge) begin
            rx_shift_d[DATA_W-1] = mosi_lvl;
            bit_cnt_d            = BW'(1);
            state_d              = RX;
            miso_d               = 1'b0;
          end
        end
        RX: begin
          miso_d = 1'b0;
          if (sample_edge) begin
            rx_shift_d[wr_idx] = mosi_lvl;
            if (bit_cnt_q == BW'(DATA_W - 1)) begin
              rx_data_d  = rx_shift_d;
              rx_valid_d = 1'b1;
              bit_cnt_d  = '0;
              state_d    = TX;
            end else begin
              bit_cnt_d = bit_cnt_q + BW'(1);
            end
          end
        end
        TX: begin
          if (sample_edge && (bit_cnt_q == BW'(DATA_W))) begin
            done_d  = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = IDLE;
          end else if (shift_edge && (bit_cnt_q < BW'(DATA_W))) begin
            miso_d    = rx_shift_q[rd_idx];
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign spi.miso    = miso_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_done  = done_q;
  assign frame_abort = abort_q;
  assign frame_cnt   = cnt_q;

endmodule

// File: tb/tb_spi_bitrev_slave.sv
// Directed testbench for spi_bitrev_slave. Five devices share one SPI master:
// the four 8-bit SPI modes on one select line (mode 3 with a 2-bit frame
// counter so wrap-around is reachable) and a 16-bit mode-0 device on a second
// select line. CPOL=1 devices see the inverted master clock.
module tb_spi_bitrev_slave;

  localparam time H = 120ns;  // half SCK period (12 system clocks)
  localparam time Q = 60ns;   // MOSI setup before the leading edge

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  logic sckp   = 1'b0;
  logic mosi   = 1'b0;
  logic ss8    = 1'b1;
  logic ss16   = 1'b1;

  always #5ns clock = ~clock;

  spi_bitrev_slave_if s0 ();
  spi_bitrev_slave_if s1 ();
  spi_bitrev_slave_if s2 ();
  spi_bitrev_slave_if s3 ();
  spi_bitrev_slave_if s16 ();

  assign s0.sck   = sckp;
  assign s1.sck   = sckp;
  assign s2.sck   = ~sckp;
  assign s3.sck   = ~sckp;
  assign s16.sck  = sckp;
  assign s0.ss    = ss8;
  assign s1.ss    = ss8;
  assign s2.ss    = ss8;
  assign s3.ss    = ss8;
  assign s16.ss   = ss16;
  assign s0.mosi  = mosi;
  assign s1.mosi  = mosi;
  assign s2.mosi  = mosi;
  assign s3.mosi  = mosi;
  assign s16.mosi = mosi;

  logic [7:0]  rxd [4];
  logic        rxv [4];
  logic        fd  [4];
  logic        fa  [4];
  logic [15:0] fc0, fc1, fc2;
  logic [1:0]  fc3;
  logic [15:0] rxd16, fc16;
  logic        rxv16, fd16, fa16;

  spi_bitrev_slave #(.DATA_W(8), .CPOL(1'b0), .CPHA(1'b0)) u0 (
    .clock(clock), .resetn(resetn), .spi(s0.slave), .rx_data(rxd[0]), .rx_valid(rxv[0]),
    .frame_done(fd[0]), .frame_abort(fa[0]), .frame_cnt(fc0));
  spi_bitrev_slave #(.DATA_W(8), .CPOL(1'b0), .CPHA(1'b1)) u1 (
    .clock(clock), .resetn(resetn), .spi(s1.slave), .rx_data(rxd[1]), .rx_valid(rxv[1]),
    .frame_done(fd[1]), .frame_abort(fa[1]), .frame_cnt(fc1));
  spi_bitrev_slave #(.DATA_W(8), .CPOL(1'b1), .CPHA(1'b0)) u2 (
    .clock(clock), .resetn(resetn), .spi(s2.slave), .rx_data(rxd[2]), .rx_valid(rxv[2]),
    .frame_done(fd[2]), .frame_abort(fa[2]), .frame_cnt(fc2));
  spi_bitrev_slave #(.DATA_W(8), .CPOL(1'b1), .CPHA(1'b1), .CNT_W(2)) u3 (
    .clock(clock), .resetn(resetn), .spi(s3.slave), .rx_data(rxd[3]), .rx_valid(rxv[3]),
    .frame_done(fd[3]), .frame_abort(fa[3]), .frame_cnt(fc3));
  spi_bitrev_slave #(.DATA_W(16), .CPOL(1'b0), .CPHA(1'b0)) u16 (
    .clock(clock), .resetn(resetn), .spi(s16.slave), .rx_data(rxd16), .rx_valid(rxv16),
    .frame_done(fd16), .frame_abort(fa16), .frame_cnt(fc16));

  // Pulse counters for the 8-bit devices; tests compare before/after deltas.
  int nval [4];
  int ndone[4];
  int nabrt[4];

  always @(posedge clock) begin
    for (int i = 0; i < 4; i++) begin
      if (rxv[i]) nval[i]  <= nval[i] + 1;
      if (fd[i])  ndone[i] <= ndone[i] + 1;
      if (fa[i])  nabrt[i] <= nabrt[i] + 1;
    end
  end

  int checks   = 0;
  int failures = 0;

  logic [31:0] rx0, rx1, rx2, rx3, rx16;
  int b_val, b_done, b_abrt, b_abrt1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One SCK cycle without reading MISO.
  task automatic sckCycle(input logic b);
    mosi = b;
    #Q;
    sckp = 1'b1;
    #H;
    sckp = 1'b0;
    #(H - Q);
  endtask

  // One full frame: n bits out MSB-first, then n cycles collecting MISO
  // MSB-first. CPHA=0 devices are read just before the leading edge,
  // CPHA=1 devices just before the trailing edge.
  task automatic applyStimulus(input int n, input logic [31:0] word);
    rx0 = '0; rx1 = '0; rx2 = '0; rx3 = '0; rx16 = '0;
    for (int c = 0; c < 2 * n; c++) begin
      if (c < n) mosi = word[n-1-c];
      else       mosi = 1'b0;
      #Q;
      if (c >= n) begin
        rx0  = {rx0[30:0],  s0.miso};
        rx2  = {rx2[30:0],  s2.miso};
        rx16 = {rx16[30:0], s16.miso};
      end
      sckp = 1'b1;
      #H;
      if (c >= n) begin
        rx1 = {rx1[30:0], s1.miso};
        rx3 = {rx3[30:0], s3.miso};
      end
      sckp = 1'b0;
      #(H - Q);
    end
    #H;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clock);
    checkOutput("reset_miso",     32'(s0.miso), 32'h1);
    checkOutput("reset_rx_data",  32'(rxd[0]),  32'h0);
    checkOutput("reset_frame_cnt", 32'(fc0),    32'h0);
    checkOutput("reset_rx_valid", 32'(rxv[0]),  32'h0);
    resetn = 1'b1;
    #H;
    checkOutput("post_reset_miso_mode3", 32'(s3.miso), 32'h1);

    // Test 1: mode 0 sends 0xB1, expects 0x8D back
    b_val = nval[0]; b_done = ndone[0]; b_abrt = nabrt[0];
    ss8 = 1'b0;
    #H;
    applyStimulus(8, 32'hB1);
    checkOutput("t1_rx_data",   32'(rxd[0]), 32'hB1);
    checkOutput("t1_returned",  rx0,         32'h8D);
    checkOutput("t1_rx_valid_n", 32'(nval[0] - b_val),  32'd1);
    checkOutput("t1_done_n",    32'(ndone[0] - b_done), 32'd1);
    checkOutput("t1_frame_cnt", 32'(fc0),    32'd1);
    checkOutput("t1_mode1_ret", rx1,         32'h8D);

    // Test 2: 0x01 on all modes, 0x80 back on each
    applyStimulus(8, 32'h01);
    checkOutput("t2_mode0_ret", rx0, 32'h80);
    checkOutput("t2_mode1_ret", rx1, 32'h80);
    checkOutput("t2_mode2_ret", rx2, 32'h80);
    checkOutput("t2_mode3_ret", rx3, 32'h80);
    checkOutput("t2_mode1_cnt", 32'(fc1), 32'd2);
    checkOutput("t2_mode2_cnt", 32'(fc2), 32'd2);
    checkOutput("t2_mode3_rxd", 32'(rxd[3]), 32'h01);

    // Test 4: back-to-back frames in one select window
    applyStimulus(8, 32'hF0);
    checkOutput("t4_first_ret", rx0, 32'h0F);
    applyStimulus(8, 32'h0F);
    checkOutput("t4_second_ret", rx0, 32'hF0);
    checkOutput("t4_mode3_second_ret", rx3, 32'hF0);
    checkOutput("t4_frame_cnt", 32'(fc0), 32'd4);
    checkOutput("t4_cnt2_wrap", 32'(fc3), 32'd0);
    ss8 = 1'b1;
    #H;
    checkOutput("t4_idle_ss_release_miso", 32'(s0.miso), 32'h1);
    checkOutput("t4_no_abort_in_idle", 32'(nabrt[0] - b_abrt), 32'd0);

    // Test 3: 16-bit device, 0x1234 -> 0x2C48
    ss16 = 1'b0;
    #H;
    applyStimulus(16, 32'h1234);
    checkOutput("t3_ret16",    rx16,        32'h2C48);
    checkOutput("t3_rx_data16", 32'(rxd16), 32'h1234);
    checkOutput("t3_cnt16",    32'(fc16),   32'd1);
    ss16 = 1'b1;
    #H;

    // Test 5: abort after 5 received bits, then a clean 0xA5 frame
    b_abrt = nabrt[0]; b_abrt1 = nabrt[1]; b_val = nval[0];
    ss8 = 1'b0;
    #H;
    for (int i = 0; i < 5; i++) sckCycle(1'b1);
    ss8 = 1'b1;
    #H;
    checkOutput("t5_abort_n",       32'(nabrt[0] - b_abrt),  32'd1);
    checkOutput("t5_abort_n_mode1", 32'(nabrt[1] - b_abrt1), 32'd1);
    checkOutput("t5_miso",          32'(s0.miso), 32'h1);
    checkOutput("t5_rx_data_kept",  32'(rxd[0]),  32'h0F);
    checkOutput("t5_frame_cnt_kept", 32'(fc0),    32'd4);
    checkOutput("t5_no_rx_valid",   32'(nval[0] - b_val), 32'd0);
    ss8 = 1'b0;
    #H;
    applyStimulus(8, 32'hA5);
    checkOutput("t5_next_ret",  rx0,         32'hA5);
    checkOutput("t5_next_rxd",  32'(rxd[0]), 32'hA5);
    checkOutput("t5_next_cnt",  32'(fc0),    32'd5);
    ss8 = 1'b1;
    #H;

    // Test 6: reset mid-TX, then wrap the 2-bit counter
    ss8 = 1'b0;
    #H;
    for (int i = 0; i < 8; i++) sckCycle(1'b1);
    for (int i = 0; i < 3; i++) sckCycle(1'b0);
    resetn = 1'b0;
    #1ns;
    checkOutput("t6_reset_miso", 32'(s0.miso), 32'h1);
    checkOutput("t6_reset_cnt",  32'(fc0),     32'd0);
    checkOutput("t6_reset_rxd",  32'(rxd[0]),  32'h0);
    checkOutput("t6_reset_cnt2", 32'(fc3),     32'd0);
    ss8 = 1'b1;
    #(H - 1ns);
    resetn = 1'b1;
    #H;
    ss8 = 1'b0;
    #H;
    applyStimulus(8, 32'h12);
    checkOutput("t6_first_after_reset", rx0, 32'h48);
    applyStimulus(8, 32'h34);
    applyStimulus(8, 32'h56);
    checkOutput("t6_cnt2_all_ones", 32'(fc3), 32'd3);
    applyStimulus(8, 32'h78);
    checkOutput("t6_cnt2_wrapped", 32'(fc3), 32'd0);
    checkOutput("t6_cnt16_four",   32'(fc0), 32'd4);
    checkOutput("t6_last_ret_mode3", rx3,    32'h1E);
    ss8 = 1'b1;
    #H;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
